projectile_controller: RTL



---
 rtl/projectile_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/projectile_controller.sv
`default_nettype none
// ============================================================================
// Module      : projectile_controller
// Description : Owns the player's single projectile: launch, climb, park.
// Revision    : 1.0 - initial release
// ============================================================================
module projectile_controller #(
  parameter int SPEED          = 4,
  parameter int START_Y        = 440,
  parameter int TOP_Y          = 16,
  parameter int MAX_X          = 639,
  parameter int PARK           = 1023,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic       clk_master,
  input  logic       d_reset,
  input  logic       proj_tick,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic       del_proj,
  output logic [9:0] projectile_x,
  output logic [9:0] projectile_y,
  output logic       proj_active,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] shots_fired
);

  localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  localparam logic [9:0]    SPEED_V = 10'(SPEED);
  localparam logic [9:0]    START_V = 10'(START_Y);
  localparam logic [9:0]    LIMIT_V = 10'(TOP_Y + SPEED);
  localparam logic [9:0]    MAX_X_V = 10'(MAX_X);
  localparam logic [9:0]    PARK_V  = 10'(PARK);
  localparam logic [CW-1:0] COOL_V  = CW'(COOLDOWN_TICKS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t        state;
  logic          fire_q;
  logic [CW-1:0] cooldown;
  logic          fire_rise;
  logic [9:0]    launch_x;

  assign fire_rise = fire & ~fire_q;
  assign launch_x  = (player_x > MAX_X_V) ? MAX_X_V : player_x;

  always_ff @(posedge clk_master) begin
    if (d_reset) begin
      state        <= IDLE;
      fire_q       <= 1'b0;
      cooldown     <= '0;
      projectile_x <= PARK_V;
      projectile_y <= PARK_V;
      proj_active  <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      shots_fired  <= 8'd0;
    end else begin
      fire_q     <= fire;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (fire_rise) begin
            projectile_x <= launch_x;
            projectile_y <= START_V;
            proj_active  <= 1'b1;
            shots_fired  <= shots_fired + 8'd1;
            state        <= FLYING;
          end
        end

        FLYING: begin
          // A hit acknowledge outranks a coincident top-exit tick.
          if (del_proj) begin
            projectile_x <= PARK_V;
            projectile_y <= PARK_V;
            proj_active  <= 1'b0;
            hit_pulse    <= 1'b1;
            cooldown     <= COOL_V;
            state        <= COOLDOWN;
          end else if (proj_tick) begin
            if (projectile_y >= LIMIT_V) begin
              projectile_y <= projectile_y - SPEED_V;
            end else begin
              projectile_x <= PARK_V;
              projectile_y <= PARK_V;
              proj_active  <= 1'b0;
              miss_pulse   <= 1'b1;
              cooldown     <= COOL_V;
              state        <= COOLDOWN;
            end
          end
        end

        COOLDOWN: begin
          if (cooldown == '0) begin
            state <= IDLE;
          end else if (proj_tick) begin
            cooldown <= cooldown - CW'(1);
          end
        end

        default: begin
          projectile_x <= PARK_V;
          projectile_y <= PARK_V;
          proj_active  <= 1'b0;
          cooldown     <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
